// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline control for the 5-stage core. Drives the enables and flushes of the
// PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It resolves
// load-use hazards, taken-branch squashes and data-memory wait states. A
// watchdog freezes the core and raises a sticky error when data memory does
// not acknowledge within MEM_TIMEOUT cycles.
//
// Optional feature macro: PIPE_PERF_EN adds stall/flush performance counters,
// the CNT_W parameter and the stall_cnt_o/flush_cnt_o ports.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   id_rs1_i, id_rs2_i                source registers of the ID instruction
//   id_use_rs1_i, id_use_rs2_i        ID instruction reads rs1 / rs2
//   ex_rd_i, ex_memread_i             EX destination register, EX is a load
//   ex_br_taken_i                     branch/jump resolved taken in EX
//   mem_req_i, mem_ready_i            MEM access request / completion
//   pc_en_o, *_en_o                   PC and stage-register enables
//   if_id_flush_o, id_ex_flush_o,
//   mem_wb_flush_o                    stage-register flushes (bubble)
//   stall_cnt_o, flush_cnt_o          perf counters (PIPE_PERF_EN only)
//   err_o                             sticky memory-timeout error
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 255
`ifdef PIPE_PERF_EN
    ,
    parameter int unsigned CNT_W       = 32
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_memread_i,
    input  logic              ex_br_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic              pc_en_o,
    output logic              if_id_en_o,
    output logic              id_ex_en_o,
    output logic              ex_mem_en_o,
    output logic              mem_wb_en_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              mem_wb_flush_o,
`ifdef PIPE_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
`endif
    output logic              err_o
);

    localparam int unsigned WCNT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit          WDOG_EN = (MEM_TIMEOUT != 0);
    // Counter value during the final tolerated stall cycle.
    localparam logic [WCNT_W-1:0] WCNT_LAST =
        WCNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;

    logic memstall;
    logic loaduse;

    assign memstall = mem_req_i & ~mem_ready_i;
    assign loaduse  = ex_memread_i & (ex_rd_i != '0) &
                      ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                       (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

    always_comb begin
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        err_d          = err_q;
        pc_en_o        = 1'b0;
        if_id_en_o     = 1'b0;
        id_ex_en_o     = 1'b0;
        ex_mem_en_o    = 1'b0;
        mem_wb_en_o    = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        mem_wb_flush_o = 1'b0;

        if (state_q != StError) begin
            if (memstall) begin
                // Let the access in MEM retire once; WB gets a bubble so the
                // held instruction is not written back twice.
                mem_wb_en_o    = 1'b1;
                mem_wb_flush_o = 1'b1;
            end else if (ex_br_taken_i) begin
                // Squash wins over load-use: the dependent ID instruction dies.
                pc_en_o       = 1'b1;
                if_id_en_o    = 1'b1;
                id_ex_en_o    = 1'b1;
                ex_mem_en_o   = 1'b1;
                mem_wb_en_o   = 1'b1;
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (loaduse) begin
                id_ex_en_o    = 1'b1;
                id_ex_flush_o = 1'b1;
                ex_mem_en_o   = 1'b1;
                mem_wb_en_o   = 1'b1;
            end else begin
                pc_en_o     = 1'b1;
                if_id_en_o  = 1'b1;
                id_ex_en_o  = 1'b1;
                ex_mem_en_o = 1'b1;
                mem_wb_en_o = 1'b1;
            end

            // wcnt is 0 in StRun, so MEM_TIMEOUT=1 goes straight to StError.
            if (memstall) begin
                if (WDOG_EN && (wcnt_q == WCNT_LAST)) begin
                    state_d = StError;
                    err_d   = 1'b1;
                end else begin
                    state_d = StMemWait;
                    wcnt_d  = wcnt_q + 1'b1;
                end
            end else begin
                state_d = StRun;
                wcnt_d  = '0;
            end
        end

        // Reset holds the whole pipeline still.
        if (rst_i) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            ex_mem_en_o    = 1'b0;
            mem_wb_en_o    = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_flush_o  = 1'b0;
            mem_wb_flush_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters; ERROR cycles are not counted as stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q != StError) && !pc_en_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (if_id_flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. Three instances share one stimulus:
// u_dut_a (MEM_TIMEOUT=255), u_dut_b (MEM_TIMEOUT=4, CNT_W=2 with
// PIPE_PERF_EN) and u_dut_c (MEM_TIMEOUT=1). Control outputs are packed as
// {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//  if_id_flush, id_ex_flush, mem_wb_flush}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] CTRL_NORMAL   = 8'b11111_000;
    localparam logic [7:0] CTRL_MEMSTALL = 8'b00001_001;
    localparam logic [7:0] CTRL_BRANCH   = 8'b11111_110;
    localparam logic [7:0] CTRL_LOADUSE  = 8'b00111_010;
    localparam logic [7:0] CTRL_ZERO     = 8'b00000_000;

    logic       clk;
    logic       rst;
    logic [4:0] rs1, rs2, exrd;
    logic       use1, use2, memread, br, req, rdy;

    logic [7:0] ctrl_a, ctrl_b, ctrl_c;
    logic       err_a, err_b, err_c;
`ifdef PIPE_PERF_EN
    logic [31:0] stall_a, flush_a, stall_c, flush_c;
    logic [1:0]  stall_b, flush_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW     (5),
        .MEM_TIMEOUT(255)
    ) u_dut_a (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_rs1_i      (rs1),
        .id_rs2_i      (rs2),
        .id_use_rs1_i  (use1),
        .id_use_rs2_i  (use2),
        .ex_rd_i       (exrd),
        .ex_memread_i  (memread),
        .ex_br_taken_i (br),
        .mem_req_i     (req),
        .mem_ready_i   (rdy),
        .pc_en_o       (ctrl_a[7]),
        .if_id_en_o    (ctrl_a[6]),
        .id_ex_en_o    (ctrl_a[5]),
        .ex_mem_en_o   (ctrl_a[4]),
        .mem_wb_en_o   (ctrl_a[3]),
        .if_id_flush_o (ctrl_a[2]),
        .id_ex_flush_o (ctrl_a[1]),
        .mem_wb_flush_o(ctrl_a[0]),
`ifdef PIPE_PERF_EN
        .stall_cnt_o   (stall_a),
        .flush_cnt_o   (flush_a),
`endif
        .err_o         (err_a)
    );

    pipe_hazard_ctrl #(
        .REG_AW     (5),
        .MEM_TIMEOUT(4)
`ifdef PIPE_PERF_EN
        ,
        .CNT_W      (2)
`endif
    ) u_dut_b (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_rs1_i      (rs1),
        .id_rs2_i      (rs2),
        .id_use_rs1_i  (use1),
        .id_use_rs2_i  (use2),
        .ex_rd_i       (exrd),
        .ex_memread_i  (memread),
        .ex_br_taken_i (br),
        .mem_req_i     (req),
        .mem_ready_i   (rdy),
        .pc_en_o       (ctrl_b[7]),
        .if_id_en_o    (ctrl_b[6]),
        .id_ex_en_o    (ctrl_b[5]),
        .ex_mem_en_o   (ctrl_b[4]),
        .mem_wb_en_o   (ctrl_b[3]),
        .if_id_flush_o (ctrl_b[2]),
        .id_ex_flush_o (ctrl_b[1]),
        .mem_wb_flush_o(ctrl_b[0]),
`ifdef PIPE_PERF_EN
        .stall_cnt_o   (stall_b),
        .flush_cnt_o   (flush_b),
`endif
        .err_o         (err_b)
    );

    pipe_hazard_ctrl #(
        .REG_AW     (5),
        .MEM_TIMEOUT(1)
    ) u_dut_c (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_rs1_i      (rs1),
        .id_rs2_i      (rs2),
        .id_use_rs1_i  (use1),
        .id_use_rs2_i  (use2),
        .ex_rd_i       (exrd),
        .ex_memread_i  (memread),
        .ex_br_taken_i (br),
        .mem_req_i     (req),
        .mem_ready_i   (rdy),
        .pc_en_o       (ctrl_c[7]),
        .if_id_en_o    (ctrl_c[6]),
        .id_ex_en_o    (ctrl_c[5]),
        .ex_mem_en_o   (ctrl_c[4]),
        .mem_wb_en_o   (ctrl_c[3]),
        .if_id_flush_o (ctrl_c[2]),
        .id_ex_flush_o (ctrl_c[1]),
        .mem_wb_flush_o(ctrl_c[0]),
`ifdef PIPE_PERF_EN
        .stall_cnt_o   (stall_c),
        .flush_cnt_o   (flush_c),
`endif
        .err_o         (err_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Benign inputs: no hazard of any kind.
    task automatic idle();
        rs1     = 5'd1;
        rs2     = 5'd2;
        use1    = 1'b1;
        use2    = 1'b1;
        exrd    = 5'd3;
        memread = 1'b0;
        br      = 1'b0;
        req     = 1'b0;
        rdy     = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        check("rst_ctrl_a", {24'd0, ctrl_a}, {24'd0, CTRL_ZERO});
        step();
        br = 1'b1;
        #1;
        check("rst_gates_br", {24'd0, ctrl_b}, {24'd0, CTRL_ZERO});
        step();
        rst = 1'b0;
        idle();
        #1;
        check("rst_err_a", {31'd0, err_a}, 32'd0);
        check("rst_err_b", {31'd0, err_b}, 32'd0);
        check("rst_err_c", {31'd0, err_c}, 32'd0);
        check("idle_a", {24'd0, ctrl_a}, {24'd0, CTRL_NORMAL});
        step();

        // Load-use on rs1, then the load leaves EX.
        memread = 1'b1;
        exrd    = 5'd5;
        rs1     = 5'd5;
        #1;
        check("lu_rs1", {24'd0, ctrl_a}, {24'd0, CTRL_LOADUSE});
        step();
        memread = 1'b0;
        #1;
        check("lu_after", {24'd0, ctrl_a}, {24'd0, CTRL_NORMAL});
        step();

        // x0 destination never stalls; unused rs2 never stalls.
        memread = 1'b1;
        exrd    = 5'd0;
        rs1     = 5'd0;
        #1;
        check("lu_x0", {24'd0, ctrl_a}, {24'd0, CTRL_NORMAL});
        step();
        exrd = 5'd7;
        rs1  = 5'd1;
        rs2  = 5'd7;
        use2 = 1'b0;
        #1;
        check("lu_rs2_unused", {24'd0, ctrl_a}, {24'd0, CTRL_NORMAL});
        step();
        use2 = 1'b1;
        #1;
        check("lu_rs2", {24'd0, ctrl_a}, {24'd0, CTRL_LOADUSE});
        step();

        // Taken branch overrides load-use.
        br = 1'b1;
        #1;
        check("br_over_lu", {24'd0, ctrl_a}, {24'd0, CTRL_BRANCH});
        step();

        // Memory stall beats branch and load-use; 3 stall cycles on A/B.
        req = 1'b1;
        #1;
        check("ms_over_br_a", {24'd0, ctrl_a}, {24'd0, CTRL_MEMSTALL});
        check("ms_over_br_b", {24'd0, ctrl_b}, {24'd0, CTRL_MEMSTALL});
        check("c_stall_pre", {31'd0, err_c}, 32'd0);
        step();
        check("c_err_1stall", {31'd0, err_c}, 32'd1);
        check("c_ctrl_err", {24'd0, ctrl_c}, {24'd0, CTRL_ZERO});
        idle();
        req = 1'b1;
        #1;
        check("ms2_a", {24'd0, ctrl_a}, {24'd0, CTRL_MEMSTALL});
        step();
        check("ms3_a", {24'd0, ctrl_a}, {24'd0, CTRL_MEMSTALL});
        step();
        rdy = 1'b1;
        #1;
        check("ms_ready_a", {24'd0, ctrl_a}, {24'd0, CTRL_NORMAL});
        check("ms_ready_b", {24'd0, ctrl_b}, {24'd0, CTRL_NORMAL});
        check("c_ignores_in", {24'd0, ctrl_c}, {24'd0, CTRL_ZERO});
        step();
        check("ms_err_a", {31'd0, err_a}, 32'd0);
        check("ms_err_b", {31'd0, err_b}, 32'd0);
        check("c_err_sticky", {31'd0, err_c}, 32'd1);

        // Reset clears ERROR on C.
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        #1;
        check("c_err_cleared", {31'd0, err_c}, 32'd0);
        check("c_ctrl_normal", {24'd0, ctrl_c}, {24'd0, CTRL_NORMAL});
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Watchdog on B: 4 stall cycles then ERROR.
        idle();
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("wd_stall_b", {24'd0, ctrl_b}, {24'd0, CTRL_MEMSTALL});
            check("wd_noerr_b", {31'd0, err_b}, 32'd0);
            step();
        end
        check("wd_err_b", {31'd0, err_b}, 32'd1);
        check("wd_ctrl_b", {24'd0, ctrl_b}, {24'd0, CTRL_ZERO});
        check("wd_err_a", {31'd0, err_a}, 32'd0);
        check("wd_ctrl_a", {24'd0, ctrl_a}, {24'd0, CTRL_MEMSTALL});
        rdy = 1'b1;
        #1;
        check("wd_rdy_ctrl_b", {24'd0, ctrl_b}, {24'd0, CTRL_ZERO});
        check("wd_rdy_ctrl_a", {24'd0, ctrl_a}, {24'd0, CTRL_NORMAL});
        step();
        check("wd_rdy_err_b", {31'd0, err_b}, 32'd1);
        rst = 1'b1;
        #1;
        check("wd_rst_ctrl_b", {24'd0, ctrl_b}, {24'd0, CTRL_ZERO});
        step();
        rst = 1'b0;
        idle();
        #1;
        check("wd_rst_err_b", {31'd0, err_b}, 32'd0);
        check("wd_rst_norm_b", {24'd0, ctrl_b}, {24'd0, CTRL_NORMAL});
        step();

        // Near miss: ready arrives in the 4th cycle, twice in a row.
        for (int r = 0; r < 2; r++) begin
            req = 1'b1;
            rdy = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step();
            end
            rdy = 1'b1;
            #1;
            check("nm_ctrl_b", {24'd0, ctrl_b}, {24'd0, CTRL_NORMAL});
            step();
            check("nm_err_b", {31'd0, err_b}, 32'd0);
        end

`ifdef PIPE_PERF_EN
        // 1 load-use + 3 memory waits + 2 taken branches.
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        memread = 1'b1;
        exrd    = 5'd5;
        rs1     = 5'd5;
        step();
        idle();
        req = 1'b1;
        step();
        step();
        step();
        idle();
        br = 1'b1;
        step();
        step();
        idle();
        step();
        check("perf_stall_a", stall_a, 32'd4);
        check("perf_flush_a", flush_a, 32'd2);
        check("perf_stall_b_sat", {30'd0, stall_b}, 32'd3);
        check("perf_flush_b", {30'd0, flush_b}, 32'd2);
        memread = 1'b1;
        exrd    = 5'd5;
        rs1     = 5'd5;
        step();
        idle();
        #1;
        check("perf_stall_a5", stall_a, 32'd5);
        check("perf_stall_b_hold", {30'd0, stall_b}, 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
